// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction memory with fixed-latency fetch and in-order response buffer
module inst_mem_resp #(
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [31:0]                  req_addr_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [31:0]                  resp_data_o,
  output logic                         resp_err_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_data_i
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int PL = LAT > 1 ? LAT - 1 : 1;
  logic [31:0]       mem [MEM_WORDS];
  logic [31:0]       bd [2**AW];
  logic [2**AW-1:0]  be;
  logic [31:0]       pd [PL];
  logic [PL-1:0]     pv, pe;
  logic [AW:0]       wr, rd;
  logic [CW-1:0]     cnt;
  logic              acc, pop, a_err, w_v, w_e;
  logic [31:0]       a_data, w_d;
  // outstanding counts in-flight plus buffered entries, so the buffer can never overflow
  assign req_ready_o  = !rst_i && cnt < CW'(BUF_DEPTH);
  assign acc          = req_valid_i && req_ready_o;
  assign resp_valid_o = !rst_i && wr != rd;
  assign pop          = resp_valid_o && resp_ready_i;
  assign a_err        = |req_addr_i[1:0] || |(req_addr_i >> (IW + 2));
  assign a_data       = a_err ? '0 : mem[req_addr_i[IW+1:2]];
  assign w_v          = LAT == 1 ? acc    : pv[PL-1];
  assign w_e          = LAT == 1 ? a_err  : pe[PL-1];
  assign w_d          = LAT == 1 ? a_data : pd[PL-1];
  assign resp_data_o  = resp_valid_o ? bd[rd[AW-1:0]] : '0;
  assign resp_err_o   = resp_valid_o && be[rd[AW-1:0]];
  always_ff @(posedge clk_i)
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  always_ff @(posedge clk_i) begin
    pd[0] <= a_data;
    for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];
    if (w_v) begin
      bd[wr[AW-1:0]] <= w_d;
      be[wr[AW-1:0]] <= w_e;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv  <= '0;
      pe  <= '0;
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      pv  <= PL'({pv, acc});
      pe  <= PL'({pe, a_err});
      wr  <= wr + (AW+1)'(w_v);
      rd  <= rd + (AW+1)'(pop);
      cnt <= cnt + CW'(acc) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed stimulus checked every cycle against a queue-based reference model
module tb_inst_mem_resp;
  localparam int LAT = 2;
  localparam int BUF = 4;
  logic        clk, rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, load_we;
  logic [31:0] req_addr, resp_data, load_data;
  logic [9:0]  load_addr;
  int n_chk = 0, n_fail = 0;

  inst_mem_resp #(.MEM_WORDS(1024), .LAT(LAT), .BUF_DEPTH(BUF)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_err_o(resp_err), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic e; int rdy;} ent_t;
  ent_t        q[$];
  ent_t        x;
  logic [31:0] mm [1024];
  int          cyc = 0, out = 0;
  bit          live = 0, m_acc, m_pop, ev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: each accepted fetch becomes visible LAT cycles later, consumed in order
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      out = 0;
      live = 1;
    end else begin
      m_acc = req_valid && out < BUF;
      m_pop = q.size() > 0 && q[0].rdy <= cyc && resp_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        x.e = req_addr[1:0] != 0 || req_addr[31:12] != 0;
        x.d = x.e ? 32'h0 : mm[req_addr[11:2]];
        x.rdy = cyc + LAT;
        q.push_back(x);
      end
      out = out + int'(m_acc) - int'(m_pop);
    end
    if (load_we) mm[load_addr] = load_data;
    cyc++;
  end

  always @(negedge clk) if (live) begin
    ev = !rst && q.size() > 0 && q[0].rdy <= cyc;
    chk("req_ready", {31'b0, req_ready}, {31'b0, !rst && out < BUF});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
    if (ev) begin
      chk("resp_data", resp_data, q[0].d);
      chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].e});
    end else if (rst) begin
      chk("rst_data", resp_data, 32'h0);
      chk("rst_err", {31'b0, resp_err}, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_we = 1; load_addr = a; load_data = d;
    tick();
    load_we = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1; req_valid = 0; req_addr = 0; resp_ready = 1;
    load_we = 0; load_addr = 0; load_data = 0;
    tick();
    load(10'd0, 32'h11111111);
    load(10'd1, 32'h22222222);
    load(10'd2, 32'h33333333);
    load(10'd3, 32'h00500093);
    load(10'd5, 32'h00000013);
    rst = 0;
    #1;
    chk("lit_ready_after_rst", {31'b0, req_ready}, 32'd1);
    // single fetch: visible exactly LAT cycles after accept
    req_valid = 1; req_addr = 32'h0C;
    tick();
    req_valid = 0;
    chk("lit_not_yet_valid", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("lit_valid_lat", {31'b0, resp_valid}, 32'd1);
    chk("lit_data_w3", resp_data, 32'h00500093);
    chk("lit_err_w3", {31'b0, resp_err}, 32'd0);
    tick();
    // back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_addr = 32'(4 * i);
      tick();
    end
    req_valid = 0;
    chk("lit_stream_w2", resp_data, 32'h33333333);
    repeat (3) tick();
    // fill the buffer with the consumer stalled
    resp_ready = 0;
    req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req_addr = (i == 3) ? 32'h0C : 32'(4 * i);
      tick();
    end
    req_addr = 32'h14;
    chk("lit_full_ready", {31'b0, req_ready}, 32'd0);
    repeat (3) tick();
    chk("lit_full_still", {31'b0, req_ready}, 32'd0);
    resp_ready = 1;
    #1;
    chk("lit_pop_cycle_ready", {31'b0, req_ready}, 32'd0);
    chk("lit_pop_cycle_head", resp_data, 32'h11111111);
    tick();
    chk("lit_ready_after_pop", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 0;
    repeat (6) tick();
    // error responses
    req_valid = 1; req_addr = 32'h02;
    tick();
    req_addr = 32'h1000;
    tick();
    req_valid = 0;
    chk("lit_err1", {31'b0, resp_err}, 32'd1);
    chk("lit_err1_data", resp_data, 32'h0);
    tick();
    chk("lit_err2", {31'b0, resp_err}, 32'd1);
    chk("lit_err2_valid", {31'b0, resp_valid}, 32'd1);
    tick();
    // reset discards in-flight work
    req_valid = 1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_valid = 0; rst = 1;
    tick();
    rst = 0;
    #1;
    chk("lit_ready_post_rst", {31'b0, req_ready}, 32'd1);
    repeat (3) begin
      tick();
      chk("lit_no_stale_resp", {31'b0, resp_valid}, 32'd0);
    end
    req_valid = 1; req_addr = 32'h0C;
    tick();
    req_valid = 0;
    tick();
    chk("lit_post_rst_data", resp_data, 32'h00500093);
    tick();
    // read-before-write on the same word
    load_we = 1; load_addr = 10'd5; load_data = 32'hDEADBEEF;
    req_valid = 1; req_addr = 32'h14;
    tick();
    load_we = 0;
    tick();
    req_valid = 0;
    chk("lit_rbw_old", resp_data, 32'h00000013);
    tick();
    chk("lit_rbw_new", resp_data, 32'hDEADBEEF);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter MEM_WORDS, default 1024, SHALL set instruction memory depth in 32-bit words; power of two.
REQ-002 Parameter LAT, default 2, SHALL set the fixed accept-to-buffer latency in cycles; legal range 1..4.
REQ-003 Parameter BUF_DEPTH, default 4, SHALL set the maximum outstanding responses (in flight plus buffered); power of two.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the reset: one clock, synchronous, active-high.
REQ-006 req_valid_i  input  1  SHALL flag a fetch request from the fetch stage.
REQ-007 req_ready_o  output  1  SHALL flag that a request can be accepted this cycle.
REQ-008 req_addr_i  input  32  SHALL carry the byte address (pc) of the request.
REQ-009 resp_valid_o  output  1  SHALL flag a valid response at the buffer head.
REQ-010 resp_ready_i  input  1  SHALL flag that the decode side consumes the head response.
REQ-011 resp_data_o  output  32  SHALL carry the instruction word of the head response.
REQ-012 resp_err_o  output  1  SHALL flag a misaligned or out-of-range request at the head.
REQ-013 load_we_i / load_addr_i / load_data_i  input  1 / log2(MEM_WORDS) / 32  SHALL form the memory preload write port (word index).

Function
REQ-014 Accept SHALL occur on a cycle with req_valid_i && req_ready_o; pop SHALL occur on a cycle with resp_valid_o && resp_ready_i.
REQ-015 req_ready_o SHALL equal (outstanding < BUF_DEPTH) computed from registered state only; there is no combinational path from resp_ready_i to req_ready_o.
REQ-016 The outstanding counter SHALL increment on accept, decrement on pop, and stay unchanged on simultaneous accept and pop.
REQ-017 At outstanding == BUF_DEPTH with a pop in the same cycle, no accept SHALL occur that cycle; req_ready_o returns high the next cycle.
REQ-018 The word index SHALL be req_addr_i[log2(MEM_WORDS)+1:2].
REQ-019 An error SHALL be recorded when req_addr_i[1:0] != 0 or any address bit above log2(MEM_WORDS)+1 is set; the error response carries data 32'h00000000 and err 1, with no memory read.
REQ-020 An accepted response SHALL enter the output buffer exactly LAT cycles after the accept edge; resp_valid_o SHALL be high from that cycle if the buffer was empty.
REQ-021 Responses SHALL be returned in request order; none dropped or duplicated.
REQ-022 The buffer head (data, err) SHALL hold stable while resp_valid_o && !resp_ready_i.
REQ-023 The buffer SHALL be circular with read/write pointers wrapping modulo BUF_DEPTH; occupancy never exceeds BUF_DEPTH by construction of REQ-015.
REQ-024 load_we_i SHALL write load_data_i to the memory at load_addr_i.
REQ-025 A same-cycle load write and request read to the same word SHALL return the old data (read-before-write).
REQ-026 Back-to-back accepts SHALL sustain one request per cycle while resp_ready_i stays high.

Reset
REQ-027 While rst_i is high: req_ready_o = 0, resp_valid_o = 0, resp_data_o = 0, resp_err_o = 0.
REQ-028 Reset SHALL clear the latency pipeline valids, the buffer pointers and the outstanding counter; in-flight and buffered responses are discarded.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Verification
REQ-031 Preload word 3 = 32'h00500093; request addr 0x0C with resp_ready_i=1 -> resp_valid_o=1 exactly LAT=2 cycles later, data 32'h00500093, err 0.
REQ-032 Requests to 0x00, 0x04, 0x08, 0x0C on consecutive cycles, resp_ready_i=1 -> four responses on four consecutive cycles, in order, starting 2 cycles after the first accept.
REQ-033 Hold resp_ready_i=0 and issue 5 requests -> 4 accepted, req_ready_o=0 after the 4th; assert resp_ready_i with req_valid_i held -> no accept in the pop cycle, 5th accepted the next cycle.
REQ-034 Request addr 0x02 and addr 0x1000 (MEM_WORDS=1024) -> both responses have err 1, data 0, returned in order.
REQ-035 Assert rst_i one cycle after two accepts -> no response ever appears for them; after reset, req_ready_o=1 and a new request returns correct data.
REQ-036 Same cycle: load write word 5 = 32'hDEADBEEF and request addr 0x14 (old value 32'h00000013) -> response 32'h00000013; the next request to 0x14 returns 32'hDEADBEEF.
